// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit.
// Optional feature macro: LSU_MISALIGN_EN (byte-beat splitting of misaligned accesses).
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // RV32I funct3 for loads/stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // data_mem mem_type encodings
  localparam logic [2:0] MT_B  = 3'b000;
  localparam logic [2:0] MT_H  = 3'b001;
  localparam logic [2:0] MT_W  = 3'b010;
  localparam logic [2:0] MT_BU = 3'b011;
  localparam logic [2:0] MT_HU = 3'b100;
  localparam logic [2:0] MT_SB = 3'b000;
  localparam logic [2:0] MT_SH = 3'b001;
  localparam logic [2:0] MT_SW = 3'b010;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [31:0] addr);
    case (f3[1:0])
      2'b01:   return addr[0];
      2'b10:   return |addr[1:0];
      default: return 1'b0;
    endcase
  endfunction

  // Reads always go out unsigned; extension happens in lsu_load_ext.
  function automatic logic [2:0] mem_type_of(input logic we, input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return we ? MT_SB : MT_BU;
      2'b01:   return we ? MT_SH : MT_HU;
      default: return we ? MT_SW : MT_W;
    endcase
  endfunction

  function automatic logic [1:0] last_beat_idx(input logic [2:0] f3);
    return (f3[1:0] == 2'b01) ? 2'd1 : 2'd3;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load result formatting: mask raw data to the access size, then sign/zero-extend.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (funct3)
      F3_B:    data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    data = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   data = {24'd0, raw[7:0]};
      F3_HU:   data = {16'd0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time between the core and data_mem.
// Optional feature macro: LSU_MISALIGN_EN splits misaligned half/word accesses into byte beats.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [2:0]  mem_type,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state_q, state_d;
  logic        we_q, err_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q, wdata_q, raw_q, ext_data;
  logic        accept, req_err, last_beat;

  assign accept = (state_q == S_IDLE) && req_valid;

`ifdef LSU_MISALIGN_EN
  logic       split_q;
  logic [1:0] beat_q;

  assign req_err   = !f3_legal(req_we, req_funct3);
  assign last_beat = !split_q || (beat_q == last_beat_idx(f3_q));
`else
  assign req_err   = !f3_legal(req_we, req_funct3) || misaligned(req_funct3, req_addr);
  assign last_beat = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      raw_q   <= 32'd0;
`ifdef LSU_MISALIGN_EN
      split_q <= 1'b0;
      beat_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= req_err;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        raw_q   <= 32'd0;
`ifdef LSU_MISALIGN_EN
        split_q <= !req_err && misaligned(req_funct3, req_addr);
        beat_q  <= 2'd0;
`endif
      end else if (state_q == S_ACCESS) begin
`ifdef LSU_MISALIGN_EN
        // Split reads assemble one byte per beat into the buffer.
        if (split_q) begin
          raw_q[{beat_q, 3'b000} +: 8] <= mem_rdata[7:0];
          beat_q                       <= beat_q + 2'd1;
        end else begin
          raw_q <= mem_rdata;
        end
`else
        raw_q <= mem_rdata;
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = req_err ? S_RESP : S_ACCESS;
      S_ACCESS: if (last_beat) state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_type  = 3'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (state_q == S_ACCESS) begin
      mem_rd_en = !we_q && !rst;
      mem_wr_en = we_q && !rst;
      mem_type  = mem_type_of(we_q, f3_q);
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
`ifdef LSU_MISALIGN_EN
      if (split_q) begin
        mem_type  = we_q ? MT_SB : MT_BU;
        mem_addr  = addr_q + {30'd0, beat_q};
        mem_wdata = {24'd0, wdata_q[{beat_q, 3'b000} +: 8]};
      end
`endif
    end
  end

  lsu_load_ext u_ext (
    .funct3 (f3_q),
    .raw    (raw_q),
    .data   (ext_data)
  );

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = (state_q == S_RESP) && err_q;
  assign resp_rdata = ((state_q == S_RESP) && !we_q && !err_q) ? ext_data : 32'd0;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu against a small byte-addressed data_mem model.
module tb_lsu;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_rd_en, mem_wr_en;
  logic [2:0]  mem_type;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int passed = 0;
  int total  = 0;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_rd_en  (mem_rd_en),
    .mem_wr_en  (mem_wr_en),
    .mem_type   (mem_type),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // data_mem model: preset contents loaded while rst is high
  logic [7:0] mem [0:255];
  logic [7:0] a0, a1, a2, a3;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[8'h05] <= 8'h11; mem[8'h06] <= 8'h11; mem[8'h07] <= 8'h11;
      mem[8'h08] <= 8'h78; mem[8'h09] <= 8'h56; mem[8'h0A] <= 8'h34; mem[8'h0B] <= 8'h12;
      mem[8'h0C] <= 8'h9A;
      mem[8'h10] <= 8'h80; mem[8'h11] <= 8'hFF;
    end else if (mem_wr_en) begin
      case (mem_type)
        3'b000: mem[a0] <= mem_wdata[7:0];
        3'b001: begin mem[a0] <= mem_wdata[7:0]; mem[a1] <= mem_wdata[15:8]; end
        3'b010: begin
          mem[a0] <= mem_wdata[7:0];   mem[a1] <= mem_wdata[15:8];
          mem[a2] <= mem_wdata[23:16]; mem[a3] <= mem_wdata[31:24];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    a0 = mem_addr[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    mem_rdata = 32'd0;
    case (mem_type)
      3'b000: mem_rdata = {{24{mem[a0][7]}}, mem[a0]};
      3'b001: mem_rdata = {{16{mem[a1][7]}}, mem[a1], mem[a0]};
      3'b010: mem_rdata = {mem[a3], mem[a2], mem[a1], mem[a0]};
      3'b011: mem_rdata = {24'd0, mem[a0]};
      3'b100: mem_rdata = {16'd0, mem[a1], mem[a0]};
      default: mem_rdata = 32'd0;
    endcase
  end

  // Issue one request (called at a negedge) and observe it until the response or a cycle budget.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output int wait_cyc, output int lat,
                        output int rd_cnt, output int wr_cnt, output logic [31:0] rdata,
                        output logic err, output logic [2:0] rtype);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    wait_cyc = 0;
    while (!req_ready && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; rd_cnt = 0; wr_cnt = 0; rdata = 32'hDEAD_DEAD; err = 1'bx; rtype = 3'b111;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (mem_rd_en) rd_cnt++;
      if (mem_wr_en) wr_cnt++;
      if (mem_rd_en || mem_wr_en) rtype = mem_type;
      if (resp_valid) begin
        lat = i; rdata = resp_rdata; err = resp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 0; req_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (mem_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", mem_wr_en); else passed++;
    total++; if (mem_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b want 0", mem_rd_en); else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready); else passed++;
    total++; if (resp_valid !== 1'b0 || resp_err !== 1'b0)
      $display("FAIL reset_resp: got valid=%b err=%b want 0/0", resp_valid, resp_err); else passed++;
    total++; if (mem_addr !== 32'd0 || mem_type !== 3'd0 || mem_wdata !== 32'd0 || resp_rdata !== 32'd0)
      $display("FAIL reset_outs: got addr=%h type=%h wdata=%h rdata=%h want 0", mem_addr, mem_type, mem_wdata, resp_rdata);
    else passed++;
  endtask

  task automatic test_load_word();
    int w, lat, rc, wc; logic [31:0] rd; logic err; logic [2:0] ty;
    do_req(1'b0, 3'b010, 32'h8, 32'h0, w, lat, rc, wc, rd, err, ty);
    total++; if (rd !== 32'h12345678) $display("FAIL lw_data: got %h want 12345678", rd); else passed++;
    total++; if (lat !== 2) $display("FAIL lw_latency: got %0d want 2", lat); else passed++;
    total++; if (rc !== 1 || wc !== 0) $display("FAIL lw_enables: got rd=%0d wr=%0d want 1/0", rc, wc); else passed++;
    total++; if (ty !== 3'b010) $display("FAIL lw_type: got %b want 010", ty); else passed++;
    total++; if (err !== 1'b0) $display("FAIL lw_err: got %b want 0", err); else passed++;
  endtask

  task automatic test_load_ext();
    logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] exps[4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFF80, 32'h0000FF80};
    logic [2:0]  tys [4] = '{3'b011, 3'b011, 3'b100, 3'b100};
    for (int k = 0; k < 4; k++) begin
      int w, lat, rc, wc; logic [31:0] rd; logic err; logic [2:0] ty;
      do_req(1'b0, f3s[k], 32'h10, 32'h0, w, lat, rc, wc, rd, err, ty);
      total++; if (rd !== exps[k] || lat !== 2)
        $display("FAIL ext_f3_%b: got %h lat %0d want %h lat 2", f3s[k], rd, lat, exps[k]); else passed++;
      total++; if (ty !== tys[k]) $display("FAIL ext_type_f3_%b: got %b want %b", f3s[k], ty, tys[k]); else passed++;
    end
  endtask

  task automatic test_misaligned();
    int w, lat, rc, wc; logic [31:0] rd; logic err; logic [2:0] ty;
    do_req(1'b1, 3'b010, 32'h5, 32'hAABBCCDD, w, lat, rc, wc, rd, err, ty);
`ifdef LSU_MISALIGN_EN
    total++; if (lat !== 5 || err !== 1'b0) $display("FAIL sw_mis_resp: got lat %0d err %b want 5/0", lat, err); else passed++;
    total++; if (wc !== 4 || ty !== 3'b000) $display("FAIL sw_mis_beats: got %0d writes type %b want 4/000", wc, ty); else passed++;
    total++; if ({mem[8], mem[7], mem[6], mem[5]} !== 32'hAABBCCDD)
      $display("FAIL sw_mis_mem: got %h want aabbccdd", {mem[8], mem[7], mem[6], mem[5]}); else passed++;
`else
    total++; if (lat !== 1 || err !== 1'b1) $display("FAIL sw_mis_err: got lat %0d err %b want 1/1", lat, err); else passed++;
    total++; if (wc !== 0 || rc !== 0) $display("FAIL sw_mis_enables: got rd=%0d wr=%0d want 0/0", rc, wc); else passed++;
    total++; if ({mem[8], mem[7], mem[6], mem[5]} !== 32'h78111111)
      $display("FAIL sw_mis_mem: got %h want 78111111", {mem[8], mem[7], mem[6], mem[5]}); else passed++;
`endif
    do_req(1'b0, 3'b010, 32'h9, 32'h0, w, lat, rc, wc, rd, err, ty);
`ifdef LSU_MISALIGN_EN
    total++; if (rd !== 32'h9A123456 || lat !== 5 || rc !== 4)
      $display("FAIL lw_mis: got %h lat %0d reads %0d want 9a123456/5/4", rd, lat, rc); else passed++;
`else
    total++; if (rd !== 32'd0 || err !== 1'b1 || lat !== 1 || rc !== 0)
      $display("FAIL lw_mis: got %h err %b lat %0d reads %0d want 0/1/1/0", rd, err, lat, rc); else passed++;
`endif
  endtask

  task automatic test_illegal();
    logic        wes[2] = '{1'b0, 1'b1};
    logic [2:0]  f3s[2] = '{3'b011, 3'b100};
    for (int k = 0; k < 2; k++) begin
      int w, lat, rc, wc; logic [31:0] rd; logic err; logic [2:0] ty;
      do_req(wes[k], f3s[k], 32'h20, 32'h12345678, w, lat, rc, wc, rd, err, ty);
      total++; if (err !== 1'b1 || lat !== 1) $display("FAIL illegal_%0d_err: got err %b lat %0d want 1/1", k, err, lat); else passed++;
      total++; if (rc !== 0 || wc !== 0 || rd !== 32'd0)
        $display("FAIL illegal_%0d_side: got rd=%0d wr=%0d data %h want 0/0/0", k, rc, wc, rd); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int w, lat, rc, wc; logic [31:0] rd; logic err; logic [2:0] ty;
    do_req(1'b1, 3'b000, 32'h20, 32'hFFFFFF5A, w, lat, rc, wc, rd, err, ty);
    total++; if (lat !== 2 || wc !== 1 || rd !== 32'd0)
      $display("FAIL sb_resp: got lat %0d writes %0d data %h want 2/1/0", lat, wc, rd); else passed++;
    do_req(1'b0, 3'b100, 32'h20, 32'h0, w, lat, rc, wc, rd, err, ty);
    total++; if (w !== 1) $display("FAIL b2b_accept: got wait %0d want 1", w); else passed++;
    total++; if (rd !== 32'h0000005A || lat !== 2) $display("FAIL b2b_lbu: got %h lat %0d want 0000005a/2", rd, lat); else passed++;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    total++; if (mem_wr_en !== 1'b0) $display("FAIL rstmid_wr_en: got %b want 0", mem_wr_en); else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    total++; if (req_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", req_ready); else passed++;
    for (int i = 0; i < 4; i++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) $display("FAIL rstmid_no_resp: got %0d responses want 0", seen); else passed++;
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_ext();
    test_misaligned();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
